// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: command/response front end,
// AW+W->B writes, AR->R reads, local rejection of unaligned commands.
module axi4_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_misaligned,
    output logic [LAT_W-1:0]    rsp_latency,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    localparam logic [LAT_W-1:0] LAT_ONE = 1;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_pend_q;
    logic                w_pend_q;
    logic [LAT_W-1:0]    lat_q;
    logic [LAT_W-1:0]    lat_inc;

    logic accept;
    logic misal;
    logic busy;
    logic b_hs;
    logic r_hs;

    assign cmd_ready = rst_n && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign misal     = (cmd_addr[1:0] != 2'b00);
    assign busy      = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                       (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign b_hs      = (state_q == WR_RESP) && bvalid;
    assign r_hs      = (state_q == RD_DATA) && rvalid;
    assign lat_inc   = (lat_q == '1) ? lat_q : lat_q + LAT_ONE;

    assign awvalid   = aw_pend_q;
    assign wvalid    = w_pend_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign arvalid   = (state_q == RD_ADDR);
    assign bready    = (state_q == WR_RESP);
    assign rready    = (state_q == RD_DATA);
    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misal)          state_d = RESP;
                    else if (cmd_write) state_d = WR_ADDR_DATA;
                    else                state_d = RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if ((!aw_pend_q || awready) && (!w_pend_q || wready))
                    state_d = WR_RESP;
            end
            WR_RESP: if (bvalid)    state_d = RESP;
            RD_ADDR: if (arready)   state_d = RD_DATA;
            RD_DATA: if (rvalid)    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Unaligned commands never touch the address/data registers, so the
    // bus only ever sees word-aligned addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_pend_q      <= 1'b0;
            w_pend_q       <= 1'b0;
            lat_q          <= '0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            rsp_misaligned <= 1'b0;
            rsp_latency    <= '0;
        end else if (accept) begin
            lat_q <= '0;
            if (misal) begin
                rsp_write      <= cmd_write;
                rsp_rdata      <= '0;
                rsp_resp       <= 2'b00;
                rsp_misaligned <= 1'b1;
                rsp_latency    <= '0;
            end else begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_pend_q <= cmd_write;
                w_pend_q  <= cmd_write;
            end
        end else begin
            if (aw_pend_q && awready) aw_pend_q <= 1'b0;
            if (w_pend_q && wready)   w_pend_q  <= 1'b0;
            if (busy)                 lat_q     <= lat_inc;
            if (b_hs) begin
                rsp_write      <= 1'b1;
                rsp_rdata      <= '0;
                rsp_resp       <= bresp;
                rsp_misaligned <= 1'b0;
                rsp_latency    <= lat_inc;
            end
            if (r_hs) begin
                rsp_write      <= 1'b0;
                rsp_rdata      <= rdata;
                rsp_resp       <= rresp;
                rsp_misaligned <= 1'b0;
                rsp_latency    <= lat_inc;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: scripted slave responses,
// scoreboard of expected responses popped on each rsp handshake.
module tb_axi4_lite_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_misaligned;
    logic [15:0] rsp_latency;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = '0;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;

    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        mis;
        logic [15:0] lat;
    } rsp_t;

    rsp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    axi4_lite_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_misaligned(rsp_misaligned),
        .rsp_latency(rsp_latency),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] exp_rdata,
                         input logic [1:0] exp_resp,
                         input logic [15:0] exp_lat, input bit keep);
        rsp_t e;
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin
            tick;
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        tick;
        if (!keep) cmd_valid = 1'b0;
        e.write = wr;
        e.mis   = (a[1:0] != 2'b00);
        e.rdata = e.mis ? 32'h0 : exp_rdata;
        e.resp  = e.mis ? 2'b00 : exp_resp;
        e.lat   = e.mis ? 16'h0 : exp_lat;
        sb_q.push_back(e);
    endtask

    task automatic wait_rsp(input string tag);
        rsp_t e;
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick;
            n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        if (rsp_valid) begin
            chk({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({tag, "_write"}, rsp_write, e.write);
                chk({tag, "_rdata"}, rsp_rdata, e.rdata);
                chk({tag, "_resp"}, rsp_resp, e.resp);
                chk({tag, "_mis"}, rsp_misaligned, e.mis);
                chk({tag, "_lat"}, rsp_latency, e.lat);
            end
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        // reset
        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_lat", rsp_latency, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_bready", bready, 0);
        chk("idle_rready", rready, 0);

        // aligned write, zero-wait slave
        awready = 1'b1;
        wready  = 1'b1;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 16'd2, 0);
        chk("w1_awvalid", awvalid, 1);
        chk("w1_wvalid", wvalid, 1);
        chk("w1_awaddr", awaddr, 32'h10);
        chk("w1_wdata", wdata, 32'hDEADBEEF);
        chk("w1_wstrb", wstrb, 4'hF);
        chk("w1_bready_early", bready, 0);
        bvalid = 1'b1;
        bresp  = 2'b00;
        tick;
        awready = 1'b0;
        wready  = 1'b0;
        chk("w1_awvalid_drop", awvalid, 0);
        chk("w1_wvalid_drop", wvalid, 0);
        chk("w1_bready", bready, 1);
        tick;
        bvalid = 1'b0;
        wait_rsp("w1");
        chk("w1_cmd_ready_after", cmd_ready, 1);

        // aligned read, arready held low 3 cycles
        issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h12345678, 2'b00, 16'd5, 0);
        chk("r1_arvalid_0", arvalid, 1);
        chk("r1_araddr_0", araddr, 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("r1_arvalid_hold", arvalid, 1);
            chk("r1_araddr_hold", araddr, 32'h4);
            chk("r1_rready_early", rready, 0);
        end
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h12345678;
        rresp   = 2'b00;
        tick;
        arready = 1'b0;
        chk("r1_arvalid_drop", arvalid, 0);
        chk("r1_rready", rready, 1);
        tick;
        rvalid = 1'b0;
        rdata  = 32'h0;
        wait_rsp("r1");

        // write, AW at T+1, W at T+4, SLVERR
        awready = 1'b1;
        issue(1'b1, 32'h40, 32'hA5A5_0F0F, 4'h6, 32'h0, 2'b10, 16'd5, 0);
        chk("w2_awaddr", awaddr, 32'h40);
        tick;
        awready = 1'b0;
        chk("w2_awvalid_drop", awvalid, 0);
        for (int i = 0; i < 2; i++) begin
            chk("w2_wvalid_hold", wvalid, 1);
            chk("w2_wdata_hold", wdata, 32'hA5A5_0F0F);
            chk("w2_bready_early", bready, 0);
            tick;
        end
        chk("w2_wvalid_hold3", wvalid, 1);
        chk("w2_bready_early3", bready, 0);
        wready = 1'b1;
        tick;
        wready = 1'b0;
        chk("w2_wvalid_drop", wvalid, 0);
        chk("w2_bready", bready, 1);
        bvalid = 1'b1;
        bresp  = 2'b10;
        tick;
        bvalid = 1'b0;
        bresp  = 2'b00;
        wait_rsp("w2");

        // misaligned read
        issue(1'b0, 32'h6, 32'h0, 4'h0, 32'h0, 2'b00, 16'd0, 0);
        chk("m1_arvalid", arvalid, 0);
        chk("m1_rsp_valid", rsp_valid, 1);
        wait_rsp("m1");

        // backpressured response with a queued command
        issue(1'b1, 32'h3, 32'h1111_2222, 4'h1, 32'h0, 2'b00, 16'd0, 1);
        cmd_write = 1'b0;
        cmd_addr  = 32'h9;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_write", rsp_write, 1);
            chk("bp_rsp_mis", rsp_misaligned, 1);
            chk("bp_awvalid", awvalid, 0);
            tick;
        end
        wait_rsp("bp1");
        chk("bp_cmd_ready_after", cmd_ready, 1);
        issue(1'b0, 32'h9, 32'h0, 4'h0, 32'h0, 2'b00, 16'd0, 0);
        wait_rsp("bp2");

        // reset while a write is pending
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00, 16'd0, 0);
        chk("rr_awvalid", awvalid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rr_awvalid_drop", awvalid, 0);
        chk("rr_wvalid_drop", wvalid, 0);
        chk("rr_rsp_valid", rsp_valid, 0);
        chk("rr_cmd_ready", cmd_ready, 0);
        sb_q.delete();
        repeat (2) tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("rr_cmd_ready_after", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rr_no_stale_rsp", rsp_valid, 0);
            chk("rr_no_awvalid", awvalid, 0);
            tick;
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator. Converts a simple command/response handshake into AXI4-Lite write (AW+W→B) and read (AR→R) transactions.
- Drives the slave under test in the AXI4-Lite environment.
- Returns raw BRESP/RRESP, read data and a per-transaction latency count.
- Unaligned commands are rejected locally and never reach the bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; WSTRB width = DATA_W/8.
- LAT_W, 16, latency counter width (saturating).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_W  read data; 0 for writes and misaligned commands.
- rsp_resp  out  2  raw BRESP/RRESP; 0 when misaligned.
- rsp_misaligned  out  1  command rejected, addr[1:0] != 0.
- rsp_latency  out  LAT_W  cycles from acceptance to B/R handshake.
- awvalid/awready/awaddr  out/in/out  1/1/ADDR_W  write address channel.
- wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_W/DATA_W/8  write data channel.
- bvalid/bready/bresp  in/out/in  1/1/2  write response channel.
- arvalid/arready/araddr  out/in/out  1/1/ADDR_W  read address channel.
- rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_W/2  read data channel.

Behaviour:
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- Reset (async assert):
  - state = IDLE.
  - All AXI valid/ready outputs = 0. All rsp_* = 0. Address/data regs = 0. Latency counter = 0.
  - cmd_ready = 0 while rst_n low.
- cmd_ready = (state == IDLE). Exactly one transaction is in flight; no new command is accepted until the response is consumed.
- Accept at edge T, aligned write:
  - Register addr/wdata/wstrb.
  - awvalid = wvalid = 1 from T+1.
  - state → WR_ADDR_DATA.
- Accept at edge T, aligned read:
  - Register addr; arvalid = 1 from T+1; state → RD_ADDR.
- Accept with cmd_addr[1:0] != 0:
  - No AXI activity. state → RESP.
  - rsp_misaligned = 1, rsp_resp = 0, rsp_latency = 0, rsp_rdata = 0, rsp_write = cmd_write.
- WR_ADDR_DATA:
  - awvalid drops the cycle after its own handshake; wvalid likewise. The two channels are tracked independently, in either order or simultaneously.
  - Once both handshakes are done → WR_RESP.
  - Valids and payload stay stable until their handshakes complete; awvalid/wvalid never drop early.
- WR_RESP: bready = 1. On bvalid, capture bresp and latency → RESP; bready = 0 next cycle.
- RD_ADDR: arvalid held stable until arready. After the handshake, arvalid = 0 → RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture rdata/rresp/latency → RESP.
- bready and rready are 0 in every other state. A bvalid/rvalid seen outside WR_RESP/RD_DATA is ignored.
- RESP:
  - rsp_valid = 1 with all rsp_* fields stable until rsp_ready.
  - On handshake: rsp_valid = 0 and state → IDLE; cmd_ready = 1 in the following cycle.
- Latency counter:
  - Cleared at acceptance, then +1 on every edge up to and including the B/R handshake edge.
  - Saturates at 2^LAT_W−1 with no wrap.
  - Minimum value is 2 (AW/W or AR handshake at T+1, B/R handshake at T+2).
- Address/strobe values are passed through unmodified. Issued awaddr/araddr are always word-aligned by construction.
- Reset mid-transaction: all valids drop immediately; the in-flight transaction is abandoned with no response.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, wstrb 0xF. Slave has awready = wready = 1 and bvalid one cycle after → awaddr = 0x10 and wdata = 0xDEADBEEF for one cycle each; rsp_write = 1, rsp_resp = 0, rsp_latency = 2.
- Read addr 0x4. Slave holds arready = 0 for 3 cycles, then rdata = 0x12345678, rresp = 0 → arvalid stable for 4 cycles; rsp_rdata = 0x12345678, rsp_latency = 5.
- Write with awready at T+1 and wready delayed to T+4 → awvalid drops at T+2 while wvalid stays high until T+4; bready rises only after T+4.
- Read addr 0x6 → no arvalid ever; rsp_misaligned = 1, rsp_latency = 0, rsp_valid the cycle after acceptance.
- rsp_ready held low 5 cycles with cmd_valid high → cmd_ready stays 0 and rsp_* stay stable; second command accepted the cycle after rsp_ready.
- Assert rst_n = 0 while awvalid = 1 → awvalid, wvalid and rsp_valid are 0 immediately. After release, cmd_ready = 1 and no stale response appears.
